motor_channel_array: RTL and testbench
======================================

// Module: motor_channel_array
// PURPOSE
//  N-channel motor I/O block. Per channel: quadrature (A/B) decode with direction, signed
//  pulse count per sample window, illegal-transition detection, and a PWM output with
//  period-aligned duty update. Uses internal clock enables on clk_sys, not divided clocks.
//  Sits between encoder pins / motor drivers and the output controller.
// PARAMETERS
//  NCH        4     number of motor channels (1..16)
//  CNT_W      8     width of signed per-window pulse count
//  PWM_W      8     PWM resolution; period = 2**PWM_W-1 PWM ticks
//  SAMPLE_DIV 50000 clk_sys cycles per sample window (>=4)
//  PWM_DIV    4     clk_sys cycles per PWM tick (>=1)
// PORTS
//  clk_sys      in  1          system clock; only clock in the block
//  rst          in  1          asynchronous, active-high reset
//  enc_a        in  NCH        encoder A per channel, asynchronous to clk_sys
//  enc_b        in  NCH        encoder B per channel, asynchronous to clk_sys
//  duty_we      in  1          write strobe for duty shadow register
//  duty_sel     in  CH_W       channel for write; CH_W = max(1,$clog2(NCH))
//  duty_data    in  PWM_W      duty value to write
//  rd_sel       in  CH_W       channel selected onto rd_count
//  rd_count     out CNT_W      signed snapshot count of rd_sel channel, combinational mux
//  sample_valid out 1          1-cycle pulse: all snapshots updated
//  dir          out NCH        1 = last valid step was forward
//  enc_err      out NCH        sticky illegal-transition flag
//  err_clr      in  1          clears all enc_err bits
//  pwm          out NCH        PWM outputs
// BEHAVIOUR
//  - Reset: all snapshots, accumulators, duty shadow/active, counters = 0; sample_valid=0,
//    dir=0, enc_err=0, pwm=0. Synchronisers reset to 0.
//  - Input path: 2-FF sync per pin, then 1 history reg. Decode {prev,cur} AB:
//    forward 00->01->11->10->00 = +1; reverse = -1; no change = 0; both bits change =
//    illegal: no count, set enc_err[i]. Pin edge to accumulator update = 3 cycles.
//  - dir[i] updates only on a +/-1 step; holds otherwise.
//  - Accumulator: signed CNT_W, saturates at +2**(CNT_W-1)-1 / -2**(CNT_W-1), no wrap.
//  - Sample tick: every SAMPLE_DIV cycles (counter 0..SAMPLE_DIV-1, tick at last).
//    On tick: snapshot <= accumulator+step (saturated); accumulator <= 0. A step in the
//    tick cycle goes into the closing window, never lost. sample_valid pulses the cycle
//    after the tick.
//  - enc_err: err_clr wins over a same-cycle illegal transition only if the transition is
//    in an earlier cycle; same-cycle set and clear -> set wins.
//  - PWM: prescaler gives ptick every PWM_DIV cycles; period counter pc counts 0..2**PWM_W-2
//    on ptick, then wraps. pwm[i] = (pc < duty_active[i]) registered. duty 0 -> constant
//    low; duty 2**PWM_W-1 -> constant high.
//  - Duty: duty_we writes duty_shadow[duty_sel]; duty_sel >= NCH ignored. duty_active
//    <= duty_shadow on ptick with pc wrap (pc==max). No glitch or mid-period change. A
//    write in the wrap cycle is not taken until the next wrap. Repeated writes in a
//    period: last one wins.
//  - rd_sel >= NCH -> rd_count = 0.
//  - Reset mid-operation: all state cleared at once, pwm low within the reset assertion.
// STRUCTURE
//  - Package motor_pkg: step encoding constants (STEP_NONE/FWD/REV/ERR), gray-order table,
//    saturating-add function.
//  - Sub-module quad_decoder_ch (sync, history, decode, accumulator, snapshot, dir, err),
//    generated NCH times. Shared sample/PWM counters and the duty array stay in the top.
// TESTING
//  - Reset, then 20 forward quadrature cycles (80 edges) on ch0 within one window ->
//    rd_count(ch0)=80 (CNT_W=8: saturates at 127 once 127 is exceeded), dir[0]=1.
//  - 10 reverse cycles on ch2 -> snapshot -40, dir[2]=0; ch0/1/3 snapshots 0.
//  - Edge in exact tick cycle -> counted in closing snapshot; next window starts at 0.
//  - AB 00->11 on ch1 -> enc_err[1]=1, count unchanged; err_clr -> 0.
//  - duty 64 on ch3 mid-period -> pwm unchanged until wrap, then high 64 of 255 ticks;
//    duty 0 -> never high; duty 255 -> always high.
//  - rst asserted mid-window with PWM high -> pwm=0, counts 0, sample_valid 0 next edge.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared definitions for the motor channel array.
// - step_e      : result of one quadrature decode (none / forward / reverse / illegal)
// - GRAY_SEQ    : forward AB order 00 -> 01 -> 11 -> 10 -> 00 ({A,B}, A is the MSB)
// - decode_step : classify a {prev,cur} AB pair
// - sat_step    : apply a step to a signed count, clamping at the w-bit signed limits
package motor_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  localparam logic [1:0] GRAY_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_e      s;
    logic [1:0] idx;
    logic [1:0] nxt;
    s = STEP_NONE;
    if ((prev ^ cur) == 2'b11) begin
      s = STEP_ERR;
    end else if (prev != cur) begin
      for (int i = 0; i < 4; i++) begin
        idx = 2'(i);
        nxt = idx + 2'd1;  // wraps 3 -> 0, closing the gray cycle
        if (GRAY_SEQ[idx] == prev) begin
          s = (GRAY_SEQ[nxt] == cur) ? STEP_FWD : STEP_REV;
        end
      end
    end
    return s;
  endfunction

  function automatic logic signed [31:0] sat_step(input logic signed [31:0] acc,
                                                  input step_e               s,
                                                  input int unsigned         w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] r;
    hi = signed'(32'd1 << (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    r  = acc;
    if (s == STEP_FWD && acc < hi) begin
      r = acc + 32'sd1;
    end else if (s == STEP_REV && acc > lo) begin
      r = acc - 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/motor_channel_array_if.sv
// Controller-side bus of the motor channel array.
// - duty_we/duty_sel/duty_data : duty shadow register write
// - rd_sel/rd_count            : snapshot read mux (signed count)
// - sample_valid               : one-cycle pulse after every snapshot update
// - err_clr                    : clears all sticky encoder error flags
interface motor_channel_array_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PWM_W = 8
);
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic                    duty_we;
  logic [CH_W-1:0]         duty_sel;
  logic [PWM_W-1:0]        duty_data;
  logic [CH_W-1:0]         rd_sel;
  logic signed [CNT_W-1:0] rd_count;
  logic                    sample_valid;
  logic                    err_clr;

  modport master (
    output duty_we, duty_sel, duty_data, rd_sel, err_clr,
    input  rd_count, sample_valid
  );

  modport slave (
    input  duty_we, duty_sel, duty_data, rd_sel, err_clr,
    output rd_count, sample_valid
  );
endinterface

// File: rtl/quad_decoder_ch.sv
// One encoder channel: 2-FF synchroniser per pin, history register, quadrature decode,
// saturating window accumulator, snapshot on sample tick, direction and sticky error.
// Ports:
//   clk_sys, rst     : clock, asynchronous active-high reset
//   enc_a, enc_b     : raw encoder pins (asynchronous)
//   tick             : last cycle of the sample window
//   err_clr          : clear enc_err (an illegal step in the same cycle wins)
//   snapshot         : signed count of the last closed window
//   dir              : 1 = last valid step was forward
//   enc_err          : sticky illegal-transition flag
module quad_decoder_ch
  import motor_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk_sys,
  input  logic                    rst,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    tick,
  input  logic                    err_clr,
  output logic signed [CNT_W-1:0] snapshot,
  output logic                    dir,
  output logic                    enc_err
);

  logic [1:0]              sync1_q, sync2_q, hist_q;
  logic signed [CNT_W-1:0] acc_q, acc_d, acc_next;
  logic signed [CNT_W-1:0] snap_q, snap_d;
  logic                    dir_q, dir_d;
  logic                    err_q, err_d;
  step_e                   step;

  always_comb begin
    step     = decode_step(hist_q, sync2_q);
    acc_next = CNT_W'(sat_step(32'(acc_q), step, CNT_W));
    // A step landing in the tick cycle belongs to the window being closed.
    acc_d    = tick ? '0 : acc_next;
    snap_d   = tick ? acc_next : snap_q;
    dir_d    = dir_q;
    if (step == STEP_FWD) begin
      dir_d = 1'b1;
    end else if (step == STEP_REV) begin
      dir_d = 1'b0;
    end
    err_d = (step == STEP_ERR) | (err_q & ~err_clr);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      acc_q   <= '0;
      snap_q  <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= {enc_a, enc_b};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      acc_q   <= acc_d;
      snap_q  <= snap_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign snapshot = snap_q;
  assign dir      = dir_q;
  assign enc_err  = err_q;

endmodule

// File: rtl/motor_channel_array.sv
// N-channel motor I/O block: per-channel quadrature decode with windowed signed counts,
// plus per-channel PWM with duty changes applied only at the period wrap.
// Ports:
//   clk_sys, rst : only clock; asynchronous active-high reset
//   enc_a, enc_b : encoder pins per channel
//   dir, enc_err : per-channel direction and sticky illegal-transition flag
//   pwm          : per-channel PWM outputs (registered)
//   bus          : controller bus (duty write, snapshot read, sample_valid, err_clr)
module motor_channel_array
  import motor_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned SAMPLE_DIV = 50000,
  parameter int unsigned PWM_DIV    = 4
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic [NCH-1:0]      enc_a,
  input  logic [NCH-1:0]      enc_b,
  output logic [NCH-1:0]      dir,
  output logic [NCH-1:0]      enc_err,
  output logic [NCH-1:0]      pwm,
  motor_channel_array_if.slave bus
);

  localparam int unsigned SMP_W  = $clog2(SAMPLE_DIV);
  localparam int unsigned PRE_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int unsigned PC_MAX = (2 ** PWM_W) - 2;

  logic [SMP_W-1:0]        smp_q, smp_d;
  logic                    tick;
  logic                    sv_q;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic                    ptick;
  logic [PWM_W-1:0]        pc_q, pc_d;
  logic                    wrap;
  logic [PWM_W-1:0]        shadow_q [NCH];
  logic [PWM_W-1:0]        shadow_d [NCH];
  logic [PWM_W-1:0]        active_q [NCH];
  logic [PWM_W-1:0]        active_d [NCH];
  logic [NCH-1:0]          pwm_q, pwm_d;
  logic signed [CNT_W-1:0] snap [NCH];

  // Shared clock enables and counters.
  always_comb begin
    tick  = (smp_q == SMP_W'(SAMPLE_DIV - 1));
    smp_d = tick ? '0 : smp_q + SMP_W'(1);
    ptick = (pre_q == PRE_W'(PWM_DIV - 1));
    pre_d = ptick ? '0 : pre_q + PRE_W'(1);
    wrap  = ptick && (pc_q == PWM_W'(PC_MAX));
    pc_d  = pc_q;
    if (ptick) begin
      pc_d = wrap ? '0 : pc_q + PWM_W'(1);
    end
  end

  // Duty shadow/active and PWM compare. The active copy only moves at the wrap, so a
  // write during the wrap cycle lands in the shadow and waits a full period.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = wrap ? shadow_q[i] : active_q[i];
      pwm_d[i]    = (pc_q < active_q[i]);
    end
    if (bus.duty_we && (32'(bus.duty_sel) < NCH)) begin
      shadow_d[bus.duty_sel] = bus.duty_data;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      smp_q <= '0;
      sv_q  <= 1'b0;
      pre_q <= '0;
      pc_q  <= '0;
      pwm_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      smp_q <= smp_d;
      sv_q  <= tick;
      pre_q <= pre_d;
      pc_q  <= pc_d;
      pwm_q <= pwm_d;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    quad_decoder_ch #(
      .CNT_W(CNT_W)
    ) u_dec (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .enc_a    (enc_a[g]),
      .enc_b    (enc_b[g]),
      .tick     (tick),
      .err_clr  (bus.err_clr),
      .snapshot (snap[g]),
      .dir      (dir[g]),
      .enc_err  (enc_err[g])
    );
  end

  always_comb begin
    bus.rd_count = '0;
    if (32'(bus.rd_sel) < NCH) begin
      bus.rd_count = snap[bus.rd_sel];
    end
  end

  assign bus.sample_valid = sv_q;
  assign pwm              = pwm_q;

endmodule

// File: tb/tb_motor_channel_array.sv
// Bench for motor_channel_array: expected window counts are queued as stimulus is driven
// and popped when sample_valid pulses; PWM behaviour is checked by counting high cycles
// against a period phase derived from the bench's own cycle count.
module tb_motor_channel_array;

  localparam int NCH        = 4;
  localparam int CNT_W      = 8;
  localparam int PWM_W      = 8;
  localparam int SAMPLE_DIV = 1000;
  localparam int PWM_DIV    = 1;
  localparam int PERIOD     = 255;

  typedef struct {
    int ch;
    int val;
  } exp_t;

  logic           clk_sys = 1'b0;
  logic           rst;
  logic [NCH-1:0] enc_a, enc_b;
  logic [NCH-1:0] dir, enc_err, pwm;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;
  int   pos [NCH];
  logic [1:0] gray_tb [4];
  exp_t sb [$];

  motor_channel_array_if #(.NCH(NCH), .CNT_W(CNT_W), .PWM_W(PWM_W)) bus ();

  motor_channel_array #(
    .NCH        (NCH),
    .CNT_W      (CNT_W),
    .PWM_W      (PWM_W),
    .SAMPLE_DIV (SAMPLE_DIV),
    .PWM_DIV    (PWM_DIV)
  ) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .dir     (dir),
    .enc_err (enc_err),
    .pwm     (pwm),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // Edges since reset release; pc seen by the pwm register after edge k is (k-1) mod 255.
  always @(posedge clk_sys or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic apply_pins();
    logic [1:0] ab;
    for (int c = 0; c < NCH; c++) begin
      ab       = gray_tb[pos[c]];
      enc_a[c] = ab[1];
      enc_b[c] = ab[0];
    end
  endtask

  task automatic step_chs(input logic [NCH-1:0] fwd, input logic [NCH-1:0] rev);
    for (int c = 0; c < NCH; c++) begin
      if (fwd[c])      pos[c] = (pos[c] + 1) % 4;
      else if (rev[c]) pos[c] = (pos[c] + 3) % 4;
    end
    apply_pins();
    repeat (4) @(posedge clk_sys);
    #1;
  endtask

  task automatic push_exp(input int ch, input int val);
    exp_t e;
    e.ch  = ch;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic wait_sv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < SAMPLE_DIV + 10 && !ok; i++) begin
      @(posedge clk_sys);
      #1;
      if (bus.sample_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic check_window(input string tag);
    bit   ok;
    exp_t e;
    int   got;
    wait_sv(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s sample_valid: got none, required a pulse within %0d cycles", tag,
               SAMPLE_DIV + 10);
      sb.delete();
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.rd_sel = 2'(e.ch);
      #1;
      got = $signed(bus.rd_count);
      vectors++;
      if (got !== e.val) begin
        miscompares++;
        $display("FAIL %s rd_count ch%0d: got %0d, required %0d", tag, e.ch, got, e.val);
      end
    end
  endtask

  task automatic test_reset();
    int got;
    rst = 1'b1;
    enc_a = '0;
    enc_b = '0;
    bus.duty_we = 1'b0;
    bus.duty_sel = '0;
    bus.duty_data = '0;
    bus.rd_sel = '0;
    bus.err_clr = 1'b0;
    for (int c = 0; c < NCH; c++) pos[c] = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    vectors++;
    if ({pwm, dir, enc_err, bus.sample_valid} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs: got pwm=%b dir=%b err=%b sv=%b, required all 0", pwm,
               dir, enc_err, bus.sample_valid);
    end
    for (int c = 0; c < NCH; c++) begin
      bus.rd_sel = 2'(c);
      #1;
      got = $signed(bus.rd_count);
      vectors++;
      if (got !== 0) begin
        miscompares++;
        $display("FAIL reset rd_count ch%0d: got %0d, required 0", c, got);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_forward();
    bit ok;
    wait_sv(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL sync sample_valid: got none, required a pulse");
    end
    repeat (80) step_chs(4'b0001, 4'b0000);
    push_exp(0, 80);
    push_exp(1, 0);
    check_window("fwd");
    vectors++;
    if (dir[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL fwd dir[0]: got %b, required 1", dir[0]);
    end
  endtask

  task automatic test_reverse();
    repeat (40) step_chs(4'b0000, 4'b0100);
    push_exp(2, -40);
    push_exp(0, 0);
    push_exp(1, 0);
    push_exp(3, 0);
    check_window("rev");
    vectors++;
    if (dir[2] !== 1'b0 || dir[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rev dir: got %b, required x0x1 pattern dir[2]=0 dir[0]=1", dir);
    end
  endtask

  // Called just after sample_valid; the next tick cycle starts SAMPLE_DIV-1 edges later,
  // and a pin change reaches the decoder two edges after it is driven.
  task automatic test_tick_edge();
    repeat (SAMPLE_DIV - 3) @(posedge clk_sys);
    #1;
    pos[0] = (pos[0] + 1) % 4;
    apply_pins();
    push_exp(0, 1);
    check_window("tick_close");
    push_exp(0, 0);
    check_window("tick_next");
  endtask

  task automatic test_illegal();
    pos[1] = 2;  // 00 -> 11
    apply_pins();
    repeat (4) @(posedge clk_sys);
    #1;
    vectors++;
    if (enc_err !== 4'b0010) begin
      miscompares++;
      $display("FAIL illegal enc_err: got %b, required 0010", enc_err);
    end
    bus.err_clr = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.err_clr = 1'b0;
    vectors++;
    if (enc_err !== 4'b0000) begin
      miscompares++;
      $display("FAIL err_clr enc_err: got %b, required 0000", enc_err);
    end
    pos[1] = 0;  // 11 -> 00, decoded in the cycle err_clr is high
    apply_pins();
    repeat (2) @(posedge clk_sys);
    #1;
    bus.err_clr = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.err_clr = 1'b0;
    vectors++;
    if (enc_err[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL set_wins enc_err[1]: got %b, required 1", enc_err[1]);
    end
    bus.err_clr = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.err_clr = 1'b0;
    vectors++;
    if (enc_err !== 4'b0000) begin
      miscompares++;
      $display("FAIL err_clr2 enc_err: got %b, required 0000", enc_err);
    end
    push_exp(1, 0);
    check_window("illegal_count");
  endtask

  task automatic test_saturate();
    repeat (160) step_chs(4'b0010, 4'b0100);
    push_exp(1, 127);
    push_exp(2, -128);
    check_window("sat");
  endtask

  task automatic write_duty(input int ch, input int val);
    bus.duty_sel  = 2'(ch);
    bus.duty_data = 8'(val);
    bus.duty_we   = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.duty_we = 1'b0;
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
      if (pwm[3] === 1'b1) hi++;
    end
  endtask

  task automatic test_pwm();
    int  ph, hi_pre, hi_lo, hi_hi, n, hi;
    bit  in_next;
    for (int i = 0; i < 2 * PERIOD && (cyc % PERIOD) != 100; i++) begin
      @(posedge clk_sys);
      #1;
    end
    write_duty(3, 64);
    hi_pre = 0; hi_lo = 0; hi_hi = 0; n = 0; in_next = 1'b0;
    for (int i = 0; i < 3 * PERIOD && n < PERIOD; i++) begin
      @(posedge clk_sys);
      #1;
      ph = (cyc - 1) % PERIOD;
      if (ph == 0) in_next = 1'b1;
      if (!in_next) begin
        if (pwm[3] === 1'b1) hi_pre++;
      end else begin
        n++;
        if (pwm[3] === 1'b1) begin
          if (ph < 64) hi_lo++;
          else         hi_hi++;
        end
      end
    end
    vectors++;
    if (hi_pre !== 0) begin
      miscompares++;
      $display("FAIL pwm64 before wrap: got %0d high cycles, required 0", hi_pre);
    end
    vectors++;
    if (hi_lo !== 64 || hi_hi !== 0) begin
      miscompares++;
      $display("FAIL pwm64 period: got %0d early/%0d late high, required 64/0", hi_lo, hi_hi);
    end
    write_duty(3, 200);
    write_duty(3, 0);
    repeat (PERIOD + 5) @(posedge clk_sys);
    #1;
    count_high(PERIOD, hi);
    vectors++;
    if (hi !== 0) begin
      miscompares++;
      $display("FAIL pwm duty0: got %0d high cycles, required 0", hi);
    end
    write_duty(3, 255);
    repeat (PERIOD + 5) @(posedge clk_sys);
    #1;
    count_high(PERIOD, hi);
    vectors++;
    if (hi !== PERIOD) begin
      miscompares++;
      $display("FAIL pwm duty255: got %0d high cycles, required %0d", hi, PERIOD);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int got;
    wait_sv(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rstmid sync: got no sample_valid, required a pulse");
    end
    repeat (5) step_chs(4'b0001, 4'b0000);
    push_exp(0, 5);
    check_window("pre_rst");
    repeat (3) step_chs(4'b0001, 4'b0000);
    rst = 1'b1;
    #1;
    vectors++;
    if (pwm !== '0 || dir !== '0 || enc_err !== '0) begin
      miscompares++;
      $display("FAIL rstmid async: got pwm=%b dir=%b err=%b, required 0", pwm, dir, enc_err);
    end
    for (int c = 0; c < NCH; c++) pos[c] = 0;
    apply_pins();
    @(posedge clk_sys);
    #1;
    vectors++;
    if (bus.sample_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid sample_valid: got %b, required 0", bus.sample_valid);
    end
    bus.rd_sel = 2'd0;
    #1;
    got = $signed(bus.rd_count);
    vectors++;
    if (got !== 0) begin
      miscompares++;
      $display("FAIL rstmid rd_count ch0: got %0d, required 0", got);
    end
    rst = 1'b0;
    push_exp(0, 0);
    check_window("post_rst");
  endtask

  initial begin
    gray_tb = '{2'b00, 2'b01, 2'b11, 2'b10};
    #3;
    test_reset();
    test_forward();
    test_reverse();
    test_tick_edge();
    test_illegal();
    test_saturate();
    test_pwm();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
